// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and forward-select encoding for the ID/EX operand stage.
// The select encoding is what fwd_mux resolves each source operand to.
package id_ex_operand_stage_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 2;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, bypass-network and ID/EX register signals of the operand stage.
// slave is the stage itself, master is whoever drives decode and observes ID/EX.
interface id_ex_operand_stage_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic              uses_rs;
   logic              uses_rt;
   logic [DATA_W-1:0] rf_data1;
   logic [DATA_W-1:0] rf_data2;
   logic [ADDR_W-1:0] rd_addr;
   logic              writes_rd;
   logic              is_load;

   logic              ex_wb_en;
   logic              ex_is_load;
   logic [ADDR_W-1:0] ex_rd;
   logic [DATA_W-1:0] ex_result;
   logic              mem_wb_en;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              flush;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_op1;
   logic [DATA_W-1:0] out_op2;
   logic [ADDR_W-1:0] out_rd;
   logic              out_writes_rd;
   logic              out_is_load;
   logic [CNT_W-1:0]  stall_count;

   modport slave (
      input  in_valid, rs_addr, rt_addr, uses_rs, uses_rt, rf_data1, rf_data2,
             rd_addr, writes_rd, is_load,
             ex_wb_en, ex_is_load, ex_rd, ex_result,
             mem_wb_en, mem_rd, mem_data, wb_en, wb_rd, wb_data,
             flush, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_rd, out_writes_rd,
             out_is_load, stall_count
   );

   modport master (
      output in_valid, rs_addr, rt_addr, uses_rs, uses_rt, rf_data1, rf_data2,
             rd_addr, writes_rd, is_load,
             ex_wb_en, ex_is_load, ex_rd, ex_result,
             mem_wb_en, mem_rd, mem_data, wb_en, wb_rd, wb_data,
             flush, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_rd, out_writes_rd,
             out_is_load, stall_count
   );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Resolves one source operand from EX / MEM / WB bypasses or the RF read port.
// Callers pass ex_en already qualified so an in-flight load never forwards from EX.
module fwd_mux
   import id_ex_operand_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] src_addr,
   input  logic              uses_src,
   input  logic              ex_en,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_en,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] operand
);

   fwd_sel_e sel;

   // Youngest producer wins; an unused source always sees the raw RF value.
   always_comb begin
      sel = FWD_RF;
      if (uses_src) begin
         if (ex_en && (ex_rd == src_addr)) begin
            sel = FWD_EX;
         end else if (mem_en && (mem_rd == src_addr)) begin
            sel = FWD_MEM;
         end else if (wb_en && (wb_rd == src_addr)) begin
            sel = FWD_WB;
         end
      end
   end

   always_comb begin
      operand = rf_data;
      case (sel)
         FWD_EX:  operand = ex_data;
         FWD_MEM: operand = mem_data;
         FWD_WB:  operand = wb_data;
         default: operand = rf_data;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwarding network, load-use bubble insertion,
// ID/EX register with valid/ready/flush and a saturating stall counter.
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input logic                clk,
   input logic                reset_n,
   id_ex_operand_stage_if.slave bus
);

   logic [DATA_W-1:0] op1_fwd;
   logic [DATA_W-1:0] op2_fwd;
   logic              ex_fwd_en;
   logic              rs_hit_load;
   logic              rt_hit_load;
   logic              hazard;

   logic              valid_q;
   logic [DATA_W-1:0] op1_q;
   logic [DATA_W-1:0] op2_q;
   logic [ADDR_W-1:0] rd_q;
   logic              writes_rd_q;
   logic              is_load_q;
   logic [CNT_W-1:0]  stall_q;

   // A load in EX has no data yet, so it is excluded from the EX bypass.
   assign ex_fwd_en = bus.ex_wb_en & ~bus.ex_is_load;

   fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rs (
      .src_addr (bus.rs_addr),
      .uses_src (bus.uses_rs),
      .ex_en    (ex_fwd_en),
      .ex_rd    (bus.ex_rd),
      .ex_data  (bus.ex_result),
      .mem_en   (bus.mem_wb_en),
      .mem_rd   (bus.mem_rd),
      .mem_data (bus.mem_data),
      .wb_en    (bus.wb_en),
      .wb_rd    (bus.wb_rd),
      .wb_data  (bus.wb_data),
      .rf_data  (bus.rf_data1),
      .operand  (op1_fwd)
   );

   fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rt (
      .src_addr (bus.rt_addr),
      .uses_src (bus.uses_rt),
      .ex_en    (ex_fwd_en),
      .ex_rd    (bus.ex_rd),
      .ex_data  (bus.ex_result),
      .mem_en   (bus.mem_wb_en),
      .mem_rd   (bus.mem_rd),
      .mem_data (bus.mem_data),
      .wb_en    (bus.wb_en),
      .wb_rd    (bus.wb_rd),
      .wb_data  (bus.wb_data),
      .rf_data  (bus.rf_data2),
      .operand  (op2_fwd)
   );

   assign rs_hit_load = bus.uses_rs & (bus.ex_rd == bus.rs_addr);
   assign rt_hit_load = bus.uses_rt & (bus.ex_rd == bus.rt_addr);
   assign hazard      = bus.in_valid & bus.ex_wb_en & bus.ex_is_load &
                        (rs_hit_load | rt_hit_load);

   assign bus.in_ready = bus.out_ready & ~bus.flush & ~hazard;

   // Rule order matters: flush beats a stalled EX, which beats the bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q     <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         rd_q        <= '0;
         writes_rd_q <= 1'b0;
         is_load_q   <= 1'b0;
         stall_q     <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (!bus.out_ready) begin
         valid_q <= valid_q;
      end else if (hazard) begin
         valid_q <= 1'b0;
         if (stall_q != {CNT_W{1'b1}}) begin
            stall_q <= stall_q + 1'b1;
         end
      end else if (bus.in_valid) begin
         valid_q     <= 1'b1;
         op1_q       <= op1_fwd;
         op2_q       <= op2_fwd;
         rd_q        <= bus.rd_addr;
         writes_rd_q <= bus.writes_rd;
         is_load_q   <= bus.is_load;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_op1       = op1_q;
   assign bus.out_op2       = op2_q;
   assign bus.out_rd        = rd_q;
   assign bus.out_writes_rd = writes_rd_q;
   assign bus.out_is_load   = is_load_q;
   assign bus.stall_count   = stall_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage; expected ID/EX contents are
// queued when an instruction is offered and popped when it appears.
module tb_id_ex_operand_stage;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   id_ex_operand_stage_if #(.DATA_W(16), .ADDR_W(2), .CNT_W(16)) bus ();

   id_ex_operand_stage #(.DATA_W(16), .ADDR_W(2), .CNT_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] op1;
      logic [15:0] op2;
      logic [1:0]  rd;
      logic        wr;
      logic        ld;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] op1, input logic [15:0] op2,
                       input logic [1:0] rd, input logic wr, input logic ld);
      exp_t e;
      e.op1 = op1; e.op2 = op2; e.rd = rd; e.wr = wr; e.ld = ld;
      sb.push_back(e);
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.rs_addr = 0; bus.rt_addr = 0; bus.uses_rs = 0; bus.uses_rt = 0;
      bus.rf_data1 = 0; bus.rf_data2 = 0; bus.rd_addr = 0; bus.writes_rd = 0; bus.is_load = 0;
      bus.ex_wb_en = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_result = 0;
      bus.mem_wb_en = 0; bus.mem_rd = 0; bus.mem_data = 0;
      bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
      bus.flush = 0; bus.out_ready = 1;
   endtask

   task automatic instr(input logic [1:0] rs, input logic urs, input logic [15:0] d1,
                        input logic [1:0] rt, input logic urt, input logic [15:0] d2,
                        input logic [1:0] rd, input logic wr, input logic ld);
      bus.in_valid = 1; bus.rs_addr = rs; bus.uses_rs = urs; bus.rf_data1 = d1;
      bus.rt_addr = rt; bus.uses_rt = urt; bus.rf_data2 = d2;
      bus.rd_addr = rd; bus.writes_rd = wr; bus.is_load = ld;
   endtask

   task automatic set_ex(input logic en, input logic ld, input logic [1:0] rd, input logic [15:0] d);
      bus.ex_wb_en = en; bus.ex_is_load = ld; bus.ex_rd = rd; bus.ex_result = d;
   endtask

   task automatic set_mem(input logic en, input logic [1:0] rd, input logic [15:0] d);
      bus.mem_wb_en = en; bus.mem_rd = rd; bus.mem_data = d;
   endtask

   task automatic set_wb(input logic en, input logic [1:0] rd, input logic [15:0] d);
      bus.wb_en = en; bus.wb_rd = rd; bus.wb_data = d;
   endtask

   task automatic check_ready(input logic exp);
      #1;
      check("in_ready", bus.in_ready, exp);
   endtask

   // One clock; afterwards compare ID/EX against the scoreboard (new capture)
   // or against the previous contents (hold).
   task automatic step(input logic exp_valid, input bit hold);
      @(posedge clk);
      @(negedge clk);
      check("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
         if (!hold) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) last = sb.pop_front();
         end
         check("out_op1", bus.out_op1, last.op1);
         check("out_op2", bus.out_op2, last.op2);
         check("out_rd", bus.out_rd, last.rd);
         check("out_writes_rd", bus.out_writes_rd, last.wr);
         check("out_is_load", bus.out_is_load, last.ld);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_op1"}, bus.out_op1, 0);
      check({tag, "_op2"}, bus.out_op2, 0);
      check({tag, "_rd"}, bus.out_rd, 0);
      check({tag, "_wr"}, bus.out_writes_rd, 0);
      check({tag, "_ld"}, bus.out_is_load, 0);
      check({tag, "_cnt"}, bus.stall_count, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      last = '{default: '0};
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1;

      // Plain RF read
      instr(0, 1, 16'h1234, 1, 1, 16'h0055, 2, 1, 0);
      check_ready(1);
      push(16'h1234, 16'h0055, 2, 1, 0);
      step(1, 0);

      // EX beats MEM on rs
      @(negedge clk);
      idle();
      instr(2, 1, 16'h7777, 3, 1, 16'h2222, 1, 1, 0);
      set_ex(1, 0, 2, 16'hBEEF);
      set_mem(1, 2, 16'h1111);
      check_ready(1);
      push(16'hBEEF, 16'h2222, 1, 1, 0);
      step(1, 0);

      // WB bypass on rt
      idle();
      instr(0, 1, 16'h0F0F, 1, 1, 16'h0000, 3, 1, 1);
      set_wb(1, 1, 16'h00AA);
      check_ready(1);
      push(16'h0F0F, 16'h00AA, 3, 1, 1);
      step(1, 0);

      // MEM beats WB on rs; unused rt ignores the matching WB
      idle();
      instr(1, 1, 16'h0001, 1, 0, 16'h3333, 0, 0, 0);
      set_mem(1, 1, 16'h4444);
      set_wb(1, 1, 16'h00AA);
      check_ready(1);
      push(16'h4444, 16'h3333, 0, 0, 0);
      step(1, 0);

      // Load in EX matching an unused source is not a hazard
      idle();
      instr(0, 1, 16'h0101, 2, 0, 16'h0202, 1, 1, 0);
      set_ex(1, 1, 2, 16'hFFFF);
      check_ready(1);
      push(16'h0101, 16'h0202, 1, 1, 0);
      step(1, 0);

      // Load-use hazard: one bubble, then the load data comes from MEM
      idle();
      instr(3, 1, 16'h9999, 0, 1, 16'h0008, 2, 1, 0);
      set_ex(1, 1, 3, 16'h0000);
      check_ready(0);
      step(0, 0);
      check("stall_after_hazard", bus.stall_count, 1);
      set_ex(0, 0, 0, 16'h0000);
      set_mem(1, 3, 16'h5A5A);
      check_ready(1);
      push(16'h5A5A, 16'h0008, 2, 1, 0);
      step(1, 0);
      check("stall_after_release", bus.stall_count, 1);

      // EX stalled for 3 cycles, with a hazard present: hold, no count
      idle();
      instr(0, 1, 16'hDEAD, 1, 1, 16'hC0DE, 3, 1, 0);
      set_ex(1, 1, 0, 16'h0000);
      bus.out_ready = 0;
      check_ready(0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1);
         check("stall_hold", bus.stall_count, 1);
      end
      set_ex(0, 0, 0, 16'h0000);
      bus.out_ready = 1;
      check_ready(1);
      push(16'hDEAD, 16'hC0DE, 3, 1, 0);
      step(1, 0);

      // Flush with hazard: bubble, no count
      set_ex(1, 1, 0, 16'h0000);
      bus.flush = 1;
      check_ready(0);
      step(0, 0);
      check("stall_flush_hazard", bus.stall_count, 1);

      // Flush with EX stalled and valid contents: flush wins
      idle();
      instr(2, 1, 16'h0A0A, 2, 1, 16'h0B0B, 1, 0, 1);
      push(16'h0A0A, 16'h0B0B, 1, 0, 1);
      step(1, 0);
      bus.flush = 1;
      bus.out_ready = 0;
      check_ready(0);
      step(0, 0);

      // No instruction offered
      idle();
      check_ready(1);
      step(0, 0);

      // Saturation of the stall counter
      instr(3, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
      set_ex(1, 1, 3, 16'h0000);
      repeat (65533) @(posedge clk);
      @(negedge clk);
      check("stall_fffe", bus.stall_count, 16'hFFFE);
      step(0, 0);
      check("stall_ffff", bus.stall_count, 16'hFFFF);
      repeat (3) step(0, 0);
      check("stall_saturated", bus.stall_count, 16'hFFFF);

      // Mid-cycle async reset after a capture
      idle();
      instr(1, 1, 16'h8001, 2, 1, 16'h8002, 3, 1, 1);
      push(16'h8001, 16'h8002, 3, 1, 1);
      step(1, 0);
      #2 reset_n = 0;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      reset_n = 1;
      instr(0, 1, 16'h4321, 3, 1, 16'h8765, 2, 1, 0);
      push(16'h4321, 16'h8765, 2, 1, 0);
      step(1, 0);
      check("stall_after_reset", bus.stall_count, 0);

      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute pipeline stage of the 16-bit pipelined CPU. Takes the two combinational read ports of the 4-entry register file plus decode fields and resolves each operand through a forwarding network (EX, MEM, WB results). It detects load-use hazards and inserts a bubble, and latches the resolved operands into the ID/EX register under a valid/ready handshake with flush. A saturating counter records stall cycles for performance analysis.

## Interface
Parameters:
- DATA_W, 16, datapath width
- ADDR_W, 2, register address width (4 registers)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- rs_addr, rt_addr  in  ADDR_W  source register addresses (also drive RF addr1/addr2)
- uses_rs, uses_rt  in  1  source actually read by the instruction
- rf_data1, rf_data2  in  DATA_W  RF read data for rs/rt
- rd_addr  in  ADDR_W  destination register
- writes_rd, is_load  in  1  instruction writes rd / is a load
- ex_wb_en, ex_is_load  in  1  EX-stage instruction writes rd / is a load
- ex_rd  in  ADDR_W; ex_result  in  DATA_W  EX-stage destination and ALU result
- mem_wb_en  in  1; mem_rd  in  ADDR_W; mem_data  in  DATA_W  MEM-stage forward source (load data included)
- wb_en  in  1; wb_rd  in  ADDR_W; wb_data  in  DATA_W  WB-stage source (same signals as RF write/addr3/data3)
- flush  in  1  squash instruction being captured
- out_ready  in  1  EX stage can accept (low stalls EX/MEM/WB together)
- out_valid  out  1; out_op1, out_op2  out  DATA_W; out_rd  out  ADDR_W; out_writes_rd, out_is_load  out  1  ID/EX register contents
- stall_count  out  CNT_W  saturating count of load-use bubble cycles

## Operation
- Operand select per source, priority: EX (ex_wb_en, ex_rd match, not ex_is_load) > MEM (mem_wb_en, mem_rd match) > WB (wb_en, wb_rd match) > RF data. WB bypass is required because RF write lands on the same edge as capture.
- Forwarding applies only when the corresponding uses_* is set; otherwise the RF value passes through unchanged.
- Load-use hazard = in_valid & ex_wb_en & ex_is_load & ((uses_rs & ex_rd==rs_addr) | (uses_rt & ex_rd==rt_addr)).
- in_ready = out_ready & ~flush & ~hazard.
- At each edge, first matching rule:
  - flush: out_valid←0.
  - out_ready low: all outputs hold.
  - hazard: out_valid←0 (bubble); stall_count increments unless saturated.
  - in_valid: capture resolved operands and fields; out_valid←1.
  - otherwise: out_valid←0.
- Bubble/flush outputs clear out_valid only; data outputs may hold stale values and are don't-care when out_valid=0.
- stall_count saturates at all-ones and is not incremented on flush or while out_ready is low.

## Timing
- Reset (async, immediate): out_valid=0, out_op1=out_op2=0, out_rd=0, out_writes_rd=0, out_is_load=0, stall_count=0. Reset mid-stall discards everything; first capture occurs on the first edge after deassertion.
- Latency: operands visible on outputs one cycle after the accepting edge.
- in_ready is combinational, with no registered state in its path.
- A load-use stall costs exactly one cycle. The next cycle the load is in MEM and is forwarded from mem_data.
- flush together with hazard: flush wins and no count is taken. Flush together with out_ready low: flush wins.

## Structure
- Shared package: DATA_W/ADDR_W defaults, forward-select encoding constants (FWD_RF, FWD_EX, FWD_MEM, FWD_WB).
- One sub-module: fwd_mux. It is instantiated twice (rs, rt) and takes source addr, uses flag and three bypass tuples plus RF data, returning the resolved operand.

## Test plan
- rf_data1=0x1234, no matching producers, in_valid=1 -> next cycle out_valid=1, out_op1=0x1234.
- rs=2, ex_rd=2 ALU result 0xBEEF, mem_rd=2 data 0x1111 -> out_op1=0xBEEF (EX priority).
- wb_en=1, wb_rd=1, wb_data=0x00AA, rt=1, rf_data2=0x0000 -> out_op2=0x00AA.
- ex_is_load, ex_rd=3, rs=3 -> in_ready=0, bubble (out_valid=0), stall_count=1. Next cycle with mem_rd=3 and mem_data=0x5A5A -> out_op1=0x5A5A.
- out_ready=0 for 3 cycles with valid contents -> outputs unchanged and stall_count unchanged. Flush asserted with hazard -> out_valid=0 and count not incremented.
- Force 2^CNT_W hazards -> stall_count stays 0xFFFF. Assert reset_n=0 mid-cycle -> all outputs 0 immediately.
